// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Field-bundle input handshake and imem write port of the
//                RV32I instruction encoder. The master is the program loader
//                and imem side; the slave is the encoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_encoder_if #(
   parameter int ADDR_W = 10
);
   // Field bundle, valid/ready handshake
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_class;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        funct3;
   logic              funct7b5;
   logic [31:0]       imm;

   // Registered imem write port with backpressure
   logic              wr_en;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport master (
      output in_valid, in_class, rd, rs1, rs2, funct3, funct7b5, imm,
      input  in_ready,
      input  wr_en, wr_addr, wr_data,
      output wr_ready
   );

   modport slave (
      input  in_valid, in_class, rd, rs1, rs2, funct3, funct7b5, imm,
      output in_ready,
      output wr_en, wr_addr, wr_data,
      input  wr_ready
   );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Sequential RV32I instruction encoder. Builds 32-bit words
//                from an instruction class plus operand fields and streams
//                them into imem at consecutive word addresses.
//                Optional macro IMM_RANGE_CHECK_EN: reject immediates that
//                cannot be represented in the selected format.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  wire                clk,
   input  wire                rst,
   input  wire                start,
   instr_encoder_if.slave     bus,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               overflow,
   output logic [ADDR_W:0]    count
);

   // FSM encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Instruction classes
   localparam logic [3:0] c_cls_load   = 4'd0;
   localparam logic [3:0] c_cls_store  = 4'd1;
   localparam logic [3:0] c_cls_rtype  = 4'd2;
   localparam logic [3:0] c_cls_itype  = 4'd3;
   localparam logic [3:0] c_cls_branch = 4'd4;
   localparam logic [3:0] c_cls_jal    = 4'd5;
   localparam logic [3:0] c_cls_jalr   = 4'd6;
   localparam logic [3:0] c_cls_lui    = 4'd7;
   localparam logic [3:0] c_cls_auipc  = 4'd8;
   localparam logic [3:0] c_cls_halt   = 4'd9;

   // Major opcodes
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_rtype  = 7'b0110011;
   localparam logic [6:0] c_op_itype  = 7'b0010011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;

   localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] c_addr_1  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   c_count_1 = (ADDR_W+1)'(1);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_wr_en;
   logic [31:0]       r_wr_data;
   logic              r_err;
   logic              r_overflow;
   logic              r_halt_pending;

   logic              w_wr_done;
   logic              w_at_last;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_legal;
   logic              w_imm_ok;
   logic              w_write;
   logic              w_is_halt;
   logic              w_session_end;
   logic              w_start_ok;
   logic [31:0]       w_word;
   logic [6:0]        w_f7;

   // Handshake and session control terms
   assign w_wr_done     = r_wr_en && bus.wr_ready;
   assign w_at_last     = &r_addr;
   // The last-address write ends the session, so nothing may be accepted
   // behind it even when it completes this cycle.
   assign w_in_ready    = (r_state == S_RUN) && !r_halt_pending &&
                          (!r_wr_en || (bus.wr_ready && !w_at_last));
   assign w_accept      = bus.in_valid && w_in_ready;
   assign w_legal       = (bus.in_class <= c_cls_halt);
   assign w_is_halt     = (bus.in_class == c_cls_halt);
   assign w_write       = w_accept && w_legal && w_imm_ok;
   assign w_session_end = w_wr_done && (r_halt_pending || w_at_last);
   assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_f7          = {1'b0, bus.funct7b5, 5'b00000};

`ifdef IMM_RANGE_CHECK_EN
   logic signed [31:0] w_simm;
   assign w_simm = $signed(bus.imm);

   // Representability of the immediate in the selected format
   always_comb begin
      w_imm_ok = 1'b1;
      case (bus.in_class)
         c_cls_load, c_cls_store, c_cls_itype, c_cls_jalr:
            w_imm_ok = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
         c_cls_branch:
            w_imm_ok = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !bus.imm[0];
         c_cls_jal:
            w_imm_ok = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574) && !bus.imm[0];
         c_cls_lui, c_cls_auipc:
            w_imm_ok = (bus.imm[11:0] == 12'h000);
         default:
            w_imm_ok = 1'b1;
      endcase
   end
`else
   assign w_imm_ok = 1'b1;
`endif

   // Field packing per instruction format
   always_comb begin
      w_word = 32'h0000_0000;
      case (bus.in_class)
         c_cls_load:
            w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, c_op_load};
         c_cls_store:
            w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], c_op_store};
         c_cls_rtype:
            w_word = {w_f7, bus.rs2, bus.rs1, bus.funct3, bus.rd, c_op_rtype};
         c_cls_itype: begin
            // Shift-immediates carry funct7 in the upper immediate bits
            if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101)
               w_word = {w_f7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, c_op_itype};
            else
               w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, c_op_itype};
         end
         c_cls_branch:
            w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      bus.imm[4:1], bus.imm[11], c_op_branch};
         c_cls_jal:
            w_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                      bus.rd, c_op_jal};
         c_cls_jalr:
            w_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, c_op_jalr};
         c_cls_lui:
            w_word = {bus.imm[31:12], bus.rd, c_op_lui};
         c_cls_auipc:
            w_word = {bus.imm[31:12], bus.rd, c_op_auipc};
         default:
            w_word = 32'h0000_0000;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)         w_state_nxt = S_RUN;
         S_RUN:   if (w_session_end) w_state_nxt = S_DONE;
         S_DONE:  if (start)         w_state_nxt = S_RUN;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs and port drive
   always_comb begin
      busy         = (r_state == S_RUN);
      done         = (r_state == S_DONE);
      err          = r_err;
      overflow     = r_overflow;
      count        = r_count;
      bus.in_ready = w_in_ready;
      bus.wr_en    = r_wr_en;
      bus.wr_addr  = r_addr;
      bus.wr_data  = r_wr_data;
   end

   // Write port, address counter and sticky status
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr         <= c_base;
         r_count        <= '0;
         r_wr_en        <= 1'b0;
         r_wr_data      <= 32'h0000_0000;
         r_err          <= 1'b0;
         r_overflow     <= 1'b0;
         r_halt_pending <= 1'b0;
      end else if (w_start_ok) begin
         r_addr         <= c_base;
         r_count        <= '0;
         r_wr_en        <= 1'b0;
         r_err          <= 1'b0;
         r_overflow     <= 1'b0;
         r_halt_pending <= 1'b0;
      end else begin
         if (w_wr_done) begin
            r_count <= r_count + c_count_1;
            // Address holds at all-ones once the top word is written
            if (w_at_last)
               r_overflow <= 1'b1;
            else
               r_addr <= r_addr + c_addr_1;
         end
         if (w_accept) begin
            r_wr_en <= w_write;
            if (w_write)
               r_wr_data <= w_word;
            else
               r_err <= 1'b1;
            if (w_write && w_is_halt)
               r_halt_pending <= 1'b1;
         end else if (w_wr_done) begin
            r_wr_en <= 1'b0;
         end
         if (w_session_end)
            r_halt_pending <= 1'b0;
      end
   end

endmodule
`default_nettype wire
